// File: rtl/decode_queue.sv
// Fetch-to-decode FIFO: classifies each ARMv4 instruction word into its decode
// family on push and presents the pre-decoded head entry to the execute side.
`timescale 1ns/1ps
module decode_queue #(
  parameter int DEPTH        = 4,
  parameter bit EXT_FAMILIES = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_ir,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_ir,
  output logic [3:0]                   out_cond,
  output logic [18:0]                  out_fam,
  output logic [4:0]                   out_fam_num,
  output logic                         out_unsup,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] ir;
    logic [18:0] fam;
    logic [4:0]  fam_num;
    logic        unsup;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          w_entry;
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]      w_num;
  logic            w_sup;
  logic            push, pop;

  // Family decode of the incoming word; priority follows the if/else order.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_num = 5'd0;
    w_sup = 1'b1;
    case (in_ir[27:25])
      3'b000: begin
        if (in_ir[24:22] == 3'b000 && in_ir[7:4] == 4'b1001)       w_num = 5'd3;
        else if (in_ir[24:23] == 2'b01 && in_ir[7:4] == 4'b1001)   w_num = 5'd4;
        else if (in_ir[24:23] == 2'b10 && in_ir[21:20] == 2'b00)
          w_num = (in_ir[7:4] == 4'b1001) ? 5'd12 : 5'd5;
        else if (in_ir[24:23] == 2'b10 && in_ir[21:20] == 2'b10 && !in_ir[4])
          w_num = 5'd7;
        else if (!in_ir[4])  w_num = 5'd1;
        else if (!in_ir[7])  w_num = 5'd2;
        else if (!in_ir[22]) w_num = 5'd11;
        else                 w_num = 5'd10;
      end
      3'b001:  w_num = (in_ir[24:23] == 2'b10 && in_ir[21:20] == 2'b10) ? 5'd6 : 5'd0;
      3'b010:  w_num = 5'd8;
      3'b011:  w_num = in_ir[4] ? 5'd15 : 5'd9;
      3'b100:  w_num = 5'd13;
      3'b101:  w_num = 5'd14;
      default: begin
        if (EXT_FAMILIES) begin
          if (!in_ir[25])      w_num = 5'd16;
          else if (!in_ir[24]) w_num = 5'd17;
          else                 w_num = 5'd18;
        end else begin
          w_sup = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    w_entry.ir      = in_ir;
    w_entry.fam     = w_sup ? (19'd1 << w_num) : 19'd0;
    w_entry.fam_num = w_num;
    w_entry.unsup   = !w_sup || (in_ir[31:28] == 4'hF);
  end

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: entry storage has no reset; the head is masked by out_valid, so stale
  // contents are never observable and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= w_entry;
  end

  // Flush outranks push/pop; pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign out_ir      = head.ir;
  assign out_cond    = head.ir[31:28];
  assign out_fam     = head.fam;
  assign out_fam_num = head.fam_num;
  assign out_unsup   = head.unsup;

endmodule

// File: tb/tb_decode_queue.sv
// Randomised and directed bench for decode_queue; two instances (extended
// families on/off) share stimulus and are checked against a queue model.
`timescale 1ns/1ps
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready, flush;
  logic [31:0] in_ir;

  logic        d1_in_ready, d1_out_valid, d1_unsup;
  logic [31:0] d1_ir;
  logic [3:0]  d1_cond;
  logic [18:0] d1_fam;
  logic [4:0]  d1_num;
  logic [CW-1:0] d1_count;

  logic        d0_in_ready, d0_out_valid, d0_unsup;
  logic [31:0] d0_ir;
  logic [3:0]  d0_cond;
  logic [18:0] d0_fam;
  logic [4:0]  d0_num;
  logic [CW-1:0] d0_count;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .EXT_FAMILIES(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d1_in_ready),
    .in_ir(in_ir), .flush(flush), .out_valid(d1_out_valid), .out_ready(out_ready),
    .out_ir(d1_ir), .out_cond(d1_cond), .out_fam(d1_fam), .out_fam_num(d1_num),
    .out_unsup(d1_unsup), .count(d1_count));

  decode_queue #(.DEPTH(DEPTH), .EXT_FAMILIES(1'b0)) dut_noext (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d0_in_ready),
    .in_ir(in_ir), .flush(flush), .out_valid(d0_out_valid), .out_ready(out_ready),
    .out_ir(d0_ir), .out_cond(d0_cond), .out_fam(d0_fam), .out_fam_num(d0_num),
    .out_unsup(d0_unsup), .count(d0_count));

  // Reference classifier: first matching (mask, match) pattern in priority order.
  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  num;
    logic        ext;
  } rule_t;

  rule_t       rules[$];
  logic [31:0] model[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void add_rule(input logic [31:0] m, input logic [31:0] v,
                                   input int n, input logic e);
    rule_t r;
    r.mask = m; r.match = v; r.num = 5'(n); r.ext = e;
    rules.push_back(r);
  endfunction

  function automatic void ref_class(input logic [31:0] ir, input logic ext,
                                    output logic [4:0] num, output logic sup);
    logic found = 1'b0;
    num = 5'd0;
    sup = 1'b0;
    foreach (rules[i]) begin
      if (!found && (ext || !rules[i].ext) && ((ir & rules[i].mask) == rules[i].match)) begin
        found = 1'b1;
        num   = rules[i].num;
        sup   = 1'b1;
      end
    end
  endfunction

  task automatic check_state(input string tag);
    logic [4:0]  n1, n0;
    logic        s1, s0;
    logic [31:0] h;
    int sz;
    sz = model.size();
    check({tag, ".count"},    64'(d1_count), 64'(sz));
    check({tag, ".count0"},   64'(d0_count), 64'(sz));
    check({tag, ".in_ready"}, 64'(d1_in_ready), 64'(sz != DEPTH));
    check({tag, ".valid"},    64'(d1_out_valid), 64'(sz != 0));
    check({tag, ".valid0"},   64'(d0_out_valid), 64'(sz != 0));
    h = (sz != 0) ? model[0] : 32'd0;
    ref_class(h, 1'b1, n1, s1);
    ref_class(h, 1'b0, n0, s0);
    if (sz == 0) begin
      check({tag, ".idle_out"}, {d1_ir, d1_cond, d1_fam, d1_num, d1_unsup}, 64'd0);
    end else begin
      check({tag, ".ir"},    64'(d1_ir), 64'(h));
      check({tag, ".cond"},  64'(d1_cond), 64'(h[31:28]));
      check({tag, ".fam"},   64'(d1_fam), s1 ? 64'(1) << n1 : 64'd0);
      check({tag, ".num"},   64'(d1_num), 64'(n1));
      check({tag, ".unsup"}, 64'(d1_unsup), 64'(!s1 || h[31:28] == 4'hF));
      check({tag, ".ir0"},   64'(d0_ir), 64'(h));
      check({tag, ".fam0"},  64'(d0_fam), s0 ? 64'(1) << n0 : 64'd0);
      check({tag, ".num0"},  64'(d0_num), 64'(n0));
      check({tag, ".unsup0"}, 64'(d0_unsup), 64'(!s0 || h[31:28] == 4'hF));
    end
  endtask

  // Drive one cycle from the negedge, advance the model, then check at the next negedge.
  task automatic cycle(input string tag, input logic v, input logic [31:0] ir,
                       input logic r, input logic f);
    int sz;
    logic do_push, do_pop;
    in_valid = v; in_ir = ir; out_ready = r; flush = f;
    sz = model.size();
    do_push = v && (sz != DEPTH);
    do_pop  = r && (sz != 0);
    if (f) model.delete();
    else begin
      if (do_pop)  void'(model.pop_front());
      if (do_push) model.push_back(ir);
    end
    @(posedge clk);
    @(negedge clk);
    check_state(tag);
  endtask

  logic [31:0] cls_ir  [6] = '{32'hE0010392, 32'hE5912000, 32'hEA000000,
                               32'hE2811001, 32'hE328F000, 32'hEF000000};
  logic [4:0]  cls_num [6] = '{5'd3, 5'd8, 5'd14, 5'd0, 5'd6, 5'd18};

  initial begin
    add_rule(32'h0FC000F0, 32'h00000090,  3, 1'b0);
    add_rule(32'h0F8000F0, 32'h00800090,  4, 1'b0);
    add_rule(32'h0FB000F0, 32'h01000090, 12, 1'b0);
    add_rule(32'h0FB00000, 32'h01000000,  5, 1'b0);
    add_rule(32'h0FB00010, 32'h01200000,  7, 1'b0);
    add_rule(32'h0E000010, 32'h00000000,  1, 1'b0);
    add_rule(32'h0E000080, 32'h00000000,  2, 1'b0);
    add_rule(32'h0E400000, 32'h00000000, 11, 1'b0);
    add_rule(32'h0E000000, 32'h00000000, 10, 1'b0);
    add_rule(32'h0FB00000, 32'h03200000,  6, 1'b0);
    add_rule(32'h0E000000, 32'h02000000,  0, 1'b0);
    add_rule(32'h0E000000, 32'h04000000,  8, 1'b0);
    add_rule(32'h0E000010, 32'h06000000,  9, 1'b0);
    add_rule(32'h0E000000, 32'h06000000, 15, 1'b0);
    add_rule(32'h0E000000, 32'h08000000, 13, 1'b0);
    add_rule(32'h0E000000, 32'h0A000000, 14, 1'b0);
    add_rule(32'h0E000000, 32'h0C000000, 16, 1'b1);
    add_rule(32'h0F000000, 32'h0E000000, 17, 1'b1);
    add_rule(32'h0E000000, 32'h0E000000, 18, 1'b1);

    rst_n = 1'b0; in_valid = 1'b0; in_ir = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;

    // Classification of known words, drained one at a time.
    for (int i = 0; i < 6; i++) begin
      cycle("cls_push", 1'b1, cls_ir[i], 1'b0, 1'b0);
      check("cls.num",   64'(d1_num), 64'(cls_num[i]));
      check("cls.unsup", 64'(d1_unsup), 64'd0);
      check("cls.cond",  64'(d1_cond), 64'hE);
      cycle("cls_pop", 1'b0, '0, 1'b1, 1'b0);
    end
    cycle("swi", 1'b1, 32'hEF000000, 1'b0, 1'b0);
    check("swi.noext.fam",   64'(d0_fam), 64'd0);
    check("swi.noext.num",   64'(d0_num), 64'd0);
    check("swi.noext.unsup", 64'(d0_unsup), 64'd1);
    cycle("swi_pop", 1'b0, '0, 1'b1, 1'b0);
    cycle("nv", 1'b1, 32'hF5912000, 1'b0, 1'b0);
    check("nv.num",    64'(d1_num), 64'd8);
    check("nv.unsup",  64'(d1_unsup), 64'd1);
    check("nv.num0",   64'(d0_num), 64'd8);
    check("nv.unsup0", 64'(d0_unsup), 64'd1);
    cycle("nv_pop", 1'b0, '0, 1'b1, 1'b0);

    // Fill past capacity, then free a slot while in_valid stays high.
    for (int i = 0; i < 5; i++) cycle("full", 1'b1, 32'hE0800000 + 32'(i), 1'b0, 1'b0);
    check("full.count", 64'(d1_count), 64'd4);
    check("full.ready", 64'(d1_in_ready), 64'd0);
    cycle("full_pop", 1'b1, 32'hE0800010, 1'b1, 1'b0);
    check("full_pop.ready", 64'(d1_in_ready), 64'd1);
    cycle("full_refill", 1'b1, 32'hE0800011, 1'b0, 1'b0);
    check("full_refill.count", 64'(d1_count), 64'd4);

    // Two entries held while pushing and popping together across pointer wrap.
    cycle("sp_flush", 1'b0, '0, 1'b0, 1'b1);
    cycle("sp_fill", 1'b1, 32'hE3A00001, 1'b0, 1'b0);
    cycle("sp_fill", 1'b1, 32'hE3A00002, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle("simul", 1'b1, 32'hE3A00010 + 32'(i), 1'b1, 1'b0);
    check("simul.count", 64'(d1_count), 64'd2);

    // Flush with three entries plus a push in the same cycle.
    cycle("fl_flush", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("fl_fill", 1'b1, 32'hE1A00000 + 32'(i), 1'b0, 1'b0);
    cycle("flush", 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    check("flush.valid", 64'(d1_out_valid), 64'd0);
    cycle("flush_after", 1'b0, '0, 1'b1, 1'b0);
    check("flush.dropped", 64'(d1_out_valid), 64'd0);

    // Asynchronous reset between edges with three entries held.
    for (int i = 0; i < 3; i++) cycle("ar_fill", 1'b1, 32'hE2400000 + 32'(i), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("areset.count", 64'(d1_count), 64'd0);
    check("areset.valid", 64'(d1_out_valid), 64'd0);
    check("areset.ready", 64'(d1_in_ready), 64'd1);
    model.delete();
    @(negedge clk);
    check_state("areset_hold");
    rst_n = 1'b1;
    cycle("ar_push", 1'b1, 32'hE0012003, 1'b0, 1'b0);
    check("ar_push.ir", 64'(d1_ir), 64'hE0012003);

    // Randomised traffic with occasional flushes, NV-condition and multiply-shaped words.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 7) == 0) w[31:28] = 4'hF;
      if ($urandom_range(0, 3) == 0) w[7:4] = 4'b1001;
      cycle("rand", $urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised fetch-to-decode buffer for the ARMv4 core. Accepts fetched 32-bit instruction words over a valid/ready handshake, classifies each word into its decode family as it is written, and stores word plus classification in a DEPTH-entry FIFO. The execute-side control FSM pops pre-decoded entries, so family decode is off its critical path. This supersedes the purely combinational family decoder. It adds buffering, flush, condition-field handling and optional extended families (coprocessor and SWI).

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- EXT_FAMILIES, 1: 1 = classify op 110/111 into families 16–18; 0 = mark them unsupported
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents in_ir
- in_ready  out  1  queue can accept
- in_ir  in  32  instruction word
- flush  in  1  synchronous discard of all entries (branch taken / exception)
- out_valid  out  1  head entry present
- out_ready  in  1  consumer takes head
- out_ir  out  32  head instruction word
- out_cond  out  4  head ir[31:28]
- out_fam  out  19  head family, one-hot
- out_fam_num  out  5  head family index
- out_unsup  out  1  head is unsupported (no family, or cond == 4'hF)
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Family decode happens on in_ir at push. Priority is top-down. op = ir[27:25].
- op 000:
  - [24:22]==000 & [7:4]==1001 → 3 (multiply)
  - else [24:23]==01 & [7:4]==1001 → 4 (multiply long)
  - else [24:23]==10 & [21:20]==00 → 12 (swap) if [7:4]==1001, otherwise 5 (MRS)
  - else [24:23]==10 & [21:20]==10 & [4]==0 → 7 (MSR register)
  - else [4]==0 → 1 (DP imm shift)
  - else [7]==0 → 2 (DP reg shift)
  - else [22]==0 → 11, otherwise 10 (halfword/signed byte)
- op 001: [24:23]==10 & [21:20]==10 → 6 (MSR immediate), otherwise 0 (DP immediate).
- op 010 → 8. op 011 → 9 if [4]==0, otherwise 15 (undefined). op 100 → 13. op 101 → 14.
- op 110/111 with EXT_FAMILIES=1: 110 → 16 (coproc load/store); 111 & [24]==0 → 17 (coproc data/register); 111 & [24]==1 → 18 (SWI).
- op 110/111 with EXT_FAMILIES=0: out_fam = 0, out_fam_num = 0, unsup = 1.
- unsup is also set when ir[31:28]==4'hF, regardless of family; out_fam and out_fam_num still hold the classified family.
- Stored per entry: ir, fam, fam_num, unsup. out_cond is taken from the stored ir.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends on count only; a pop in the same cycle does not raise it.
- out_valid = (count != 0). When out_valid=0, all out_* data outputs are driven 0.
- Read and write pointers wrap modulo DEPTH.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- flush has priority over push and pop: pointers and count go to 0, and any same-cycle push is dropped.

## Timing
- Reset (async, rst_n low): pointers = 0, count = 0, out_valid = 0, out_* = 0, in_ready = 1. Release is synchronous to clk.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: a word pushed at edge N is visible on out_* after edge N (same cycle N+1), if the queue was empty. No bypass path from in_ir to out_*.
- Throughput: one push and one pop per cycle in steady state.
- out_* are stable while out_valid=1 & out_ready=0.
- Flush at edge N: out_valid = 0 and count = 0 after edge N; in_ready = 1.
- All outputs come from registered state plus combinational read of the head entry. No combinational in→out path.

## Test plan
- Classification, EXT_FAMILIES=1, drain each word:
  - 0xE0010392 → fam_num 3
  - 0xE5912000 → 8
  - 0xEA000000 → 14
  - 0xE2811001 → 0
  - 0xE328F000 → 6
  - 0xEF000000 → 18
  - all with unsup = 0 and out_cond = 4'hE
- Mode/cond: 0xEF000000 with EXT_FAMILIES=0 → fam 0, num 0, unsup 1. 0xF5912000 (either mode) → num 8, unsup 1.
- Full: DEPTH=4, out_ready=0, push 5 words → count saturates at 4, in_ready=0, 5th word not accepted. Then pop one with in_valid held → in_ready=1 the next cycle, count returns to 4.
- Simultaneous push/pop with 2 entries held for 8 cycles → count stays 2, order preserved across pointer wrap.
- Flush with 3 entries plus a same-cycle push → count=0, out_valid=0 next cycle. The dropped word never appears at the output.
- Async reset: assert rst_n low between clock edges with 3 entries held → count=0, out_valid=0, in_ready=1 immediately. After release, the first push appears one cycle later.
